// File: rtl/branch_predictor_unit_pkg.sv
// Shared types and helpers for the branch predictor: entry types, BTB entry layout,
// saturating-counter arithmetic and the counter reset value.
package bp_pkg;

  localparam int unsigned BP_MAX_XLEN = 64;
  localparam int unsigned BP_MAX_CTR  = 4;

  typedef enum logic [1:0] {
    BP_COND = 2'd0,
    BP_JUMP = 2'd1,
    BP_CALL = 2'd2,
    BP_RET  = 2'd3
  } bp_type_e;

  // Tag and target are stored at the widest supported XLEN and zero-extended.
  typedef struct packed {
    logic                   valid;
    logic [BP_MAX_XLEN-1:0] tag;
    logic [BP_MAX_XLEN-1:0] target;
    bp_type_e               btype;
  } btb_entry_t;

  // Weakly-not-taken for the default 2-bit counter; ctr_reset() covers other widths.
  localparam logic [BP_MAX_CTR-1:0] BP_CTR_RST_DEF = 4'd1;

  function automatic logic [BP_MAX_CTR-1:0] ctr_reset(input int unsigned bits);
    return BP_MAX_CTR'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [BP_MAX_CTR-1:0] sat_update(input logic [BP_MAX_CTR-1:0] counter,
                                                       input logic taken,
                                                       input int unsigned bits);
    logic [BP_MAX_CTR-1:0] max_v;
    max_v = BP_MAX_CTR'((1 << bits) - 1);
    if (taken) return (counter == max_v) ? counter : counter + 4'd1;
    return (counter == '0) ? counter : counter - 4'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch-lookup and execute-update signal bundle of the branch predictor.
// master = fetch/execute pipeline side, slave = predictor.
interface branch_predictor_unit_if #(
  parameter int XLEN = 32,
  parameter int IW   = 6
) ();
  import bp_pkg::*;

  logic            lookup_valid_i;
  logic [XLEN-1:0] lookup_pc_i;
  logic            btb_hit_o;
  logic            predict_taken_o;
  logic [XLEN-1:0] predicted_pc_o;
  logic [IW-1:0]   lookup_index_o;
  logic            update_valid_i;
  logic [XLEN-1:0] update_pc_i;
  logic [IW-1:0]   update_index_i;
  logic            update_taken_i;
  logic [XLEN-1:0] update_target_i;
  bp_type_e        update_type_i;
  logic            flush_i;

  modport master (
    output lookup_valid_i, lookup_pc_i,
    input  btb_hit_o, predict_taken_o, predicted_pc_o, lookup_index_o,
    output update_valid_i, update_pc_i, update_index_i, update_taken_i,
    output update_target_i, update_type_i, flush_i
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i,
    output btb_hit_o, predict_taken_o, predicted_pc_o, lookup_index_o,
    input  update_valid_i, update_pc_i, update_index_i, update_taken_i,
    input  update_target_i, update_type_i, flush_i
  );
endinterface

// File: rtl/branch_predictor_unit_ras.sv
// Circular return-address stack with occupancy count; used only when BP_RAS_EN is defined.
// A push into a full stack overwrites the oldest entry.
module bp_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] stack_q [DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign ptr_inc = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
  assign top_o   = stack_q[ptr_q];
  assign empty_o = (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push_i) begin
      ptr_d = ptr_inc;
      cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_dec;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && push_i && !flush_i) stack_q[ptr_inc] <= data_i;
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB plus PHT of saturating counters, bimodal or gshare indexed.
// Optional return-address stack enabled by defining BP_RAS_EN.
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BTB_ENTRIES  = 64,
  parameter int COUNTER_BITS = 2,
  parameter int INDEX_MODE   = 0,
  parameter int HIST_BITS    = 6,
  parameter int RAS_DEPTH    = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  branch_predictor_unit_if.slave bp
);
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - IW - 2;
  localparam logic [COUNTER_BITS-1:0] CTR_RST = COUNTER_BITS'(ctr_reset(COUNTER_BITS));

  btb_entry_t              btb_q [BTB_ENTRIES];
  logic [COUNTER_BITS-1:0] pht_q [BTB_ENTRIES];
  logic [HIST_BITS-1:0]    ghr_q;

  logic [IW-1:0]   lk_idx, lk_pidx, up_idx;
  logic [TW-1:0]   lk_tag, up_tag;
  logic [XLEN-1:0] pc_seq, lk_target;
  logic            lk_hit, lk_taken, up_taken;
  bp_type_e        lk_type;

  assign lk_idx  = bp.lookup_pc_i[IW+1:2];
  assign lk_tag  = bp.lookup_pc_i[XLEN-1:IW+2];
  assign lk_pidx = (INDEX_MODE == 1) ? (lk_idx ^ IW'(ghr_q)) : lk_idx;
  assign pc_seq  = bp.lookup_pc_i + XLEN'(4);
  assign lk_type = btb_q[lk_idx].btype;

  // Lookups read registered state only, so a same-cycle update is not visible yet.
  assign lk_hit   = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == BP_MAX_XLEN'(lk_tag));
  assign lk_taken = lk_hit && ((lk_type != BP_COND) || pht_q[lk_pidx][COUNTER_BITS-1]);

`ifdef BP_RAS_EN
  logic            ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0] ras_top;

  assign ras_push = bp.lookup_valid_i && lk_hit && (lk_type == BP_CALL);
  assign ras_pop  = bp.lookup_valid_i && lk_hit && (lk_type == BP_RET);

  bp_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bp.flush_i),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_seq),
    .top_o   (ras_top),
    .empty_o (ras_empty)
  );

  assign lk_target = ((lk_type == BP_RET) && !ras_empty) ? ras_top
                                                         : btb_q[lk_idx].target[XLEN-1:0];
`else
  assign lk_target = btb_q[lk_idx].target[XLEN-1:0];
`endif

  assign bp.btb_hit_o       = rst_i && lk_hit;
  assign bp.predict_taken_o = rst_i && lk_taken;
  assign bp.predicted_pc_o  = (rst_i && lk_taken) ? lk_target : pc_seq;
  assign bp.lookup_index_o  = lk_pidx;

  // Unconditional control flow always trains toward taken.
  assign up_taken = bp.update_taken_i || (bp.update_type_i != BP_COND);
  assign up_idx   = bp.update_pc_i[IW+1:2];
  assign up_tag   = bp.update_pc_i[XLEN-1:IW+2];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        pht_q[i]       <= CTR_RST;
      end
      ghr_q <= '0;
    end else if (bp.update_valid_i) begin
      pht_q[bp.update_index_i] <= COUNTER_BITS'(sat_update(BP_MAX_CTR'(pht_q[bp.update_index_i]),
                                                           up_taken, COUNTER_BITS));
      if (up_taken) begin
        btb_q[up_idx] <= '{valid:  1'b1,
                           tag:    BP_MAX_XLEN'(up_tag),
                           target: BP_MAX_XLEN'(bp.update_target_i),
                           btype:  bp.update_type_i};
      end
      if (bp.update_type_i == BP_COND) ghr_q <= (ghr_q << 1) | HIST_BITS'(bp.update_taken_i);
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench for branch_predictor_unit: directed scenarios plus randomized traffic
// compared against a table-level model; one bimodal and one gshare instance.
module tb_branch_predictor_unit;
  import bp_pkg::*;

  localparam int ENT = 64;
  localparam int IW  = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_unit_if #(.XLEN(32), .IW(IW)) bif ();
  branch_predictor_unit_if #(.XLEN(32), .IW(IW)) gif ();

  branch_predictor_unit #(.XLEN(32), .BTB_ENTRIES(ENT), .COUNTER_BITS(2), .INDEX_MODE(0),
                          .HIST_BITS(6), .RAS_DEPTH(4))
    u_bim (.clk_i(clk), .rst_i(rst_n), .bp(bif.slave));

  branch_predictor_unit #(.XLEN(32), .BTB_ENTRIES(ENT), .COUNTER_BITS(2), .INDEX_MODE(1),
                          .HIST_BITS(6), .RAS_DEPTH(4))
    u_gsh (.clk_i(clk), .rst_i(rst_n), .bp(gif.slave));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain tables indexed by pc/4 mod ENT, tag = pc/(4*ENT), counters 0..3.
  bit              m_val [ENT];
  int unsigned     m_tag [ENT];
  logic [31:0]     m_tgt [ENT];
  int              m_type[ENT];
  int              m_ctr [ENT];
  logic [31:0]     m_ras [$];

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_val[i] = 1'b0;
      m_ctr[i] = 1;
    end
    m_ras.delete();
  endfunction

  function automatic void m_predict(input logic [31:0] pc, output bit hit, output bit tk,
                                    output logic [31:0] pred, output int i);
    i    = int'((pc / 4) % ENT);
    hit  = rst_n && m_val[i] && (m_tag[i] == pc / (4 * ENT));
    tk   = hit && (m_type[i] != 0 || m_ctr[i] >= 2);
    pred = pc + 32'd4;
    if (tk) pred = m_tgt[i];
`ifdef BP_RAS_EN
    if (tk && m_type[i] == 3 && m_ras.size() > 0) pred = m_ras[$];
`endif
  endfunction

  function automatic void m_ras_step(input logic [31:0] pc, input bit hit, input int i);
    if (hit && m_type[i] == 2) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (hit && m_type[i] == 3 && m_ras.size() > 0) begin
      void'(m_ras.pop_back());
    end
  endfunction

  function automatic void m_update(input logic [31:0] pc, input int pidx, input bit taken,
                                   input logic [31:0] tgt, input int typ, input bit flush);
    int i;
    bit tk;
    i  = int'((pc / 4) % ENT);
    tk = taken || (typ != 0);
    m_ctr[pidx] = tk ? ((m_ctr[pidx] < 3) ? m_ctr[pidx] + 1 : 3)
                     : ((m_ctr[pidx] > 0) ? m_ctr[pidx] - 1 : 0);
    if (tk) begin
      m_val[i]  = 1'b1;
      m_tag[i]  = pc / (4 * ENT);
      m_tgt[i]  = tgt;
      m_type[i] = typ;
    end
    if (flush) m_ras.delete();
  endfunction

  task automatic check_outputs(input logic [31:0] pc, input string tag, output bit hit,
                               output int i);
    bit tk;
    logic [31:0] pred;
    m_predict(pc, hit, tk, pred, i);
    chk({tag, ".hit"}, bif.btb_hit_o, hit);
    chk({tag, ".tkn"}, bif.predict_taken_o, tk);
    chk({tag, ".npc"}, bif.predicted_pc_o, pred);
    chk({tag, ".idx"}, bif.lookup_index_o, i);
  endtask

  task automatic lookup(input logic [31:0] pc, input string tag, output int idx_o,
                        output logic [31:0] pred_o);
    bit hit;
    int i;
    @(negedge clk);
    bif.lookup_pc_i    = pc;
    bif.lookup_valid_i = 1'b1;
    #1;
    check_outputs(pc, tag, hit, i);
    idx_o  = int'(bif.lookup_index_o);
    pred_o = bif.predicted_pc_o;
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_ras_step(pc, hit, i);
    #1;
    bif.lookup_valid_i = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input int pidx, input bit taken,
                        input logic [31:0] tgt, input int typ, input bit flush);
    @(negedge clk);
    bif.update_valid_i  = 1'b1;
    bif.update_pc_i     = pc;
    bif.update_index_i  = IW'(pidx);
    bif.update_taken_i  = taken;
    bif.update_target_i = tgt;
    bif.update_type_i   = bp_type_e'(typ);
    bif.flush_i         = flush;
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_update(pc, pidx, taken, tgt, typ, flush);
    #1;
    bif.update_valid_i = 1'b0;
    bif.flush_i        = 1'b0;
  endtask

  initial begin
    int          idx;
    logic [31:0] pred;
    bit          hit;
    int          ii;
    int          g_ghr;
    int          g_ctr[ENT];
    bit          g_alloc;
    int          mis;
    logic [31:0] exp_ret[4];

    bif.lookup_valid_i = 0; bif.lookup_pc_i = 0; bif.update_valid_i = 0; bif.update_pc_i = 0;
    bif.update_index_i = 0; bif.update_taken_i = 0; bif.update_target_i = 0;
    bif.update_type_i = BP_COND; bif.flush_i = 0;
    gif.lookup_valid_i = 0; gif.lookup_pc_i = 0; gif.update_valid_i = 0; gif.update_pc_i = 0;
    gif.update_index_i = 0; gif.update_taken_i = 0; gif.update_target_i = 0;
    gif.update_type_i = BP_COND; gif.flush_i = 0;
    m_reset();

    repeat (2) @(posedge clk);
    lookup(32'h100, "in_rst", idx, pred);
    chk("in_rst.npc_const", pred, 32'h104);
    @(negedge clk);
    rst_n = 1'b1;

    lookup(32'h100, "post_rst", idx, pred);
    chk("post_rst.npc_const", pred, 32'h104);

    update(32'h100, 0, 1'b1, 32'h200, 0, 1'b0);
    update(32'h100, 0, 1'b1, 32'h200, 0, 1'b0);
    lookup(32'h100, "tt", idx, pred);
    chk("tt.npc_const", pred, 32'h200);
    update(32'h100, 0, 1'b0, 32'h200, 0, 1'b0);
    update(32'h100, 0, 1'b0, 32'h200, 0, 1'b0);
    lookup(32'h100, "ttnn", idx, pred);
    chk("ttnn.npc_const", pred, 32'h104);

    for (int k = 0; k < 5; k++) update(32'h104, 1, 1'b1, 32'h300, 0, 1'b0);
    update(32'h104, 1, 1'b0, 32'h300, 0, 1'b0);
    lookup(32'h104, "sat", idx, pred);
    chk("sat.tkn_const", bif.predict_taken_o, 1'b1);

    update(32'h100, 0, 1'b1, 32'h500, 0, 1'b0);
    update(32'h100 + 4 * ENT, 0, 1'b1, 32'h600, 0, 1'b0);
    lookup(32'h100, "alias_old", idx, pred);
    chk("alias_old.hit_const", bif.btb_hit_o, 1'b0);
    lookup(32'h100 + 4 * ENT, "alias_new", idx, pred);

    update(32'h108, 2, 1'b0, 32'h700, 0, 1'b0);
    lookup(32'h108, "nt_noalloc", idx, pred);
    update(32'h10C, 3, 1'b0, 32'h900, 1, 1'b0);
    lookup(32'h10C, "jump_nt", idx, pred);
    chk("jump_nt.npc_const", pred, 32'h900);
    lookup(32'hFFFF_FFFC, "wrap", idx, pred);
    chk("wrap.npc_const", pred, 32'h0);

    // Update and lookup of the same entry in one cycle: old value before the edge, new after.
    @(negedge clk);
    bif.update_valid_i = 1'b1; bif.update_pc_i = 32'h110; bif.update_index_i = IW'(4);
    bif.update_taken_i = 1'b1; bif.update_target_i = 32'hA00; bif.update_type_i = BP_COND;
    bif.lookup_pc_i = 32'h110;
    #1;
    check_outputs(32'h110, "same_pre", hit, ii);
    @(posedge clk);
    m_update(32'h110, 4, 1'b1, 32'hA00, 0, 1'b0);
    #1;
    bif.update_valid_i = 1'b0;
    #1;
    check_outputs(32'h110, "same_post", hit, ii);

    // Reset arriving together with an update discards the update.
    @(negedge clk);
    rst_n = 1'b0;
    update(32'h114, 5, 1'b1, 32'hB00, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h114, "rst_drop", idx, pred);
    lookup(32'h10C, "rst_clear", idx, pred);

    // Calls at 0x10..0x50 and a return at 0x80.
    for (int k = 1; k <= 5; k++) update(32'(k * 16), k * 4, 1'b1, 32'(32'h1000 + k * 16), 2, 1'b0);
    update(32'h80, 32, 1'b1, 32'hBEE0, 3, 1'b0);
    for (int k = 1; k <= 5; k++) lookup(32'(k * 16), "call", idx, pred);
`ifdef BP_RAS_EN
    exp_ret[0] = 32'h54; exp_ret[1] = 32'h44; exp_ret[2] = 32'h34; exp_ret[3] = 32'h24;
`else
    for (int k = 0; k < 4; k++) exp_ret[k] = 32'hBEE0;
`endif
    for (int k = 0; k < 4; k++) begin
      lookup(32'h80, "ret", idx, pred);
      chk("ret.npc_const", pred, exp_ret[k]);
    end
    lookup(32'h80, "ret_empty", idx, pred);
    chk("ret_empty.npc_const", pred, 32'hBEE0);
    lookup(32'h10, "call2", idx, pred);
    lookup(32'h20, "call2", idx, pred);
    update(32'h80, 32, 1'b1, 32'hBEE0, 3, 1'b1);
    lookup(32'h80, "ret_flush", idx, pred);
    chk("ret_flush.npc_const", pred, 32'hBEE0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] rpc;
      int typ;
      rpc = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 2) * 4 * ENT);
      typ = int'($urandom_range(0, 3));
      lookup(rpc, "rnd", idx, pred);
      update(rpc, idx, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, typ,
             ($urandom_range(0, 7) == 0));
    end

    // Gshare: alternating outcomes on one branch train two history-indexed counters.
    g_ghr = 0;
    g_alloc = 1'b0;
    mis = 0;
    for (int i = 0; i < ENT; i++) g_ctr[i] = 1;
    for (int n = 0; n < 20; n++) begin
      bit actual;
      bit g_pred;
      int gi;
      actual = (n % 2 == 0);
      @(negedge clk);
      gif.lookup_pc_i = 32'h100;
      gif.lookup_valid_i = 1'b1;
      #1;
      gi = g_ghr;
      chk("g.idx", gif.lookup_index_o, gi);
      chk("g.tkn", gif.predict_taken_o, g_alloc && g_ctr[gi] >= 2);
      g_pred = gif.predict_taken_o;
      if (n >= 12 && g_pred != actual) mis++;
      gif.update_valid_i = 1'b1; gif.update_pc_i = 32'h100;
      gif.update_index_i = gif.lookup_index_o; gif.update_taken_i = actual;
      gif.update_target_i = 32'h200; gif.update_type_i = BP_COND;
      @(posedge clk);
      #1;
      gif.update_valid_i = 1'b0;
      gif.lookup_valid_i = 1'b0;
      g_ctr[gi] = actual ? ((g_ctr[gi] < 3) ? g_ctr[gi] + 1 : 3)
                         : ((g_ctr[gi] > 0) ? g_ctr[gi] - 1 : 0);
      if (actual) g_alloc = 1'b1;
      g_ghr = ((g_ghr << 1) | int'(actual)) & 63;
    end
    chk("g.mis_last8", mis, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
- Parametrised branch predictor for the fetch stage.
- Holds a direct-mapped branch target buffer (BTB) and a separate pattern history table (PHT) of N-bit saturating counters.
- PHT index mode is selectable: bimodal, or gshare using a global history register (GHR).
- Fetch performs a combinational lookup. Execute resolves branches and writes back, carrying the lookup index with the instruction so the PHT update hits the same entry.

Parameters:
- XLEN, 32, address width.
- BTB_ENTRIES, 64, BTB and PHT depth; power of two, min 4.
- COUNTER_BITS, 2, saturating counter width; range 1..4.
- INDEX_MODE, 0, PHT indexing: 0 = bimodal, 1 = gshare.
- HIST_BITS, 6, GHR width; must be ≤ log2(BTB_ENTRIES).
- RAS_DEPTH, 4, return-address stack depth; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- lookup_valid_i  in  1  fetch lookup qualifier.
- lookup_pc_i  in  XLEN  fetch PC.
- btb_hit_o  out  1  BTB valid and tag match.
- predict_taken_o  out  1  predicted taken.
- predicted_pc_o  out  XLEN  next-PC prediction.
- lookup_index_o  out  log2(BTB_ENTRIES)  PHT index; pipelined alongside the instruction.
- update_valid_i  in  1  resolved control instruction in execute.
- update_pc_i  in  XLEN  PC of the resolved instruction.
- update_index_i  in  log2(BTB_ENTRIES)  PHT index returned from fetch.
- update_taken_i  in  1  actual outcome.
- update_target_i  in  XLEN  actual target.
- update_type_i  in  2  entry type: 0 cond, 1 jump, 2 call, 3 return.
- flush_i  in  1  pipeline flush on mispredict.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- While rst_i is low:
  - All BTB valid bits are cleared.
  - Every PHT counter is set to weakly-not-taken, 2^(COUNTER_BITS-1)-1.
  - GHR is set to 0.
  - Outputs are forced to btb_hit_o=0, predict_taken_o=0, predicted_pc_o=lookup_pc_i+4.
- Reset asserted mid-operation discards any update presented in the same cycle.
- BTB indexing:
  - idx = lookup_pc_i[IW+1:2], where IW = log2(BTB_ENTRIES).
  - tag = lookup_pc_i[XLEN-1:IW+2].
- PHT indexing:
  - Bimodal: pidx = idx.
  - Gshare: pidx = idx XOR zero-extended GHR.
  - lookup_index_o = pidx.
- Lookup timing: combinational read of registered state. Zero cycles of latency, no bypass. An update and a lookup to the same entry in the same cycle: the lookup sees the pre-update value.
- btb_hit_o = valid[idx] and tag match.
- predict_taken_o = btb_hit_o and (type != cond, or counter MSB = 1).
- predicted_pc_o = stored target when taken, else lookup_pc_i+4. The addition wraps modulo 2^XLEN.
- Update, on a clock edge with update_valid_i=1:
  - PHT[update_index_i] saturates: increment if taken, decrement if not. No wrap at 0 or at max.
  - If taken, the BTB entry at update_pc_i's index is written with valid, tag, target and type. A tag conflict overwrites the existing entry.
  - A not-taken outcome never allocates a BTB entry and leaves existing entries intact.
- GHR:
  - Shifts left with update_taken_i only when update_valid_i=1 and type = cond.
  - Updates are non-speculative.
  - flush_i does not affect the GHR.
- update_valid_i with update_type_i = jump/call/return always counts as taken. The counter update still applies.

Optional Feature:
- Macro: BP_RAS_EN.
- Defined:
  - A circular RAS of RAS_DEPTH entries plus an occupancy count.
  - Push lookup_pc_i+4 when lookup_valid_i is high and the lookup hits a call entry.
  - Return hit with non-empty RAS: predicted_pc_o = top of stack, then pop.
  - Return hit with empty RAS: use the BTB target; the pointer does not move.
  - Push when full overwrites the oldest entry; the count stays at RAS_DEPTH.
  - flush_i empties the RAS.
  - Reset empties the RAS.
- Undefined: no RAS storage; returns are predicted from the BTB target only.

Decomposition:
- Package bp_pkg holds:
  - enum bp_type_e {BP_COND, BP_JUMP, BP_CALL, BP_RET}.
  - Struct btb_entry_t {valid, tag, target, type}.
  - Function sat_update(counter, taken).
  - Localparam for the counter reset value.
- Sub-module bp_ras: the stack, its pointer/count logic, and push/pop/flush. It is instantiated only under BP_RAS_EN.

Test Plan:
- Reset, then lookup pc=0x100 → hit=0, taken=0, predicted_pc=0x104.
- Bimodal, 2-bit counters. Update pc=0x100, cond, taken, target=0x200, twice.
  - Lookup 0x100 → hit=1, taken=1, predicted_pc=0x200.
  - Two not-taken updates → taken=0, predicted_pc=0x104.
- Five taken updates on one entry, then one not-taken, then lookup → taken=1. Confirms saturation at 3, then 2.
- Alias: update pc=0x100 then pc=0x100+4*BTB_ENTRIES, both taken, different targets → lookup 0x100 gives hit=0.
- Gshare: same pc, alternating outcomes T,N,T,N… for 20 updates, each update using the index returned by its own lookup → mispredict count in the last 8 updates = 0.
- BP_RAS_EN, RAS_DEPTH=4.
  - Five call hits at pc 0x10,0x20,0x30,0x40,0x50, then four return hits → predicted 0x54,0x44,0x34,0x24.
  - A fifth return uses the BTB target.
  - flush_i mid-sequence → the next return uses the BTB target.
